// File: rtl/memory_stage_if.sv
// M-side bundle registered by the execute stage and consumed by the memory stage.
// The execute stage drives it through the master modport; memory_stage reads it through slave.
interface memory_stage_if;
   logic        RegWriteM;
   logic        MemWriteM;
   logic        ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] ALU_ResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;

   modport master (
      output RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M
   );

   modport slave (
      input  RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: word-addressed data memory with async read and sync write, plus the M/W
// pipeline register. ResultW is muxed combinationally from W for the execute-stage forwarding path.
module memory_stage #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                rst,
   memory_stage_if.slave       m_if,
   output logic                RegWriteW,
   output logic                ResultSrcW,
   output logic [4:0]          RD_W,
   output logic [31:0]         ALU_ResultW,
   output logic [31:0]         ReadDataW,
   output logic [31:0]         PCPlus4W,
   output logic                MisalignW,
   output logic [31:0]         ResultW
);

   if (DEPTH != (1 << ADDR_W)) begin : g_bad_param
      $error("memory_stage: DEPTH must equal 2**ADDR_W");
   end

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];

   logic [ADDR_W-1:0] word_idx;
   logic              misalign;
   logic [31:0]       rd_word;
   logic              unused_hi_addr;

   logic              reg_write_d, reg_write_q;
   logic              result_src_d, result_src_q;
   logic [4:0]        rd_d, rd_q;
   logic [31:0]       alu_result_d, alu_result_q;
   logic [31:0]       read_data_d, read_data_q;
   logic [31:0]       pc_plus4_d, pc_plus4_q;
   logic              misalign_d, misalign_q;

   // Upper address bits are dropped on purpose so accesses wrap modulo the memory size.
   assign unused_hi_addr = ^m_if.ALU_ResultM[31:ADDR_W+2];

   always_comb begin
      word_idx = m_if.ALU_ResultM[ADDR_W+1:2];
      misalign = (|m_if.ALU_ResultM[1:0]) & (m_if.MemWriteM | m_if.ResultSrcM);
      rd_word  = mem_q[word_idx];

      // Read sees the pre-store word, so a load+store encoding returns old data.
      mem_d = mem_q;
      if (m_if.MemWriteM && !misalign) begin
         mem_d[word_idx] = m_if.WriteDataM;
      end

      reg_write_d  = m_if.RegWriteM & ~(misalign & m_if.ResultSrcM);
      result_src_d = m_if.ResultSrcM;
      rd_d         = m_if.RD_M;
      alu_result_d = m_if.ALU_ResultM;
      read_data_d  = rd_word;
      pc_plus4_d   = m_if.PCPlus4M;
      misalign_d   = misalign;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q        <= '{default: '0};
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
         pc_plus4_q   <= '0;
         misalign_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         pc_plus4_q   <= pc_plus4_d;
         misalign_q   <= misalign_d;
      end
   end

   assign RegWriteW   = reg_write_q;
   assign ResultSrcW  = result_src_q;
   assign RD_W        = rd_q;
   assign ALU_ResultW = alu_result_q;
   assign ReadDataW   = read_data_q;
   assign PCPlus4W    = pc_plus4_q;
   assign MisalignW   = misalign_q;
   assign ResultW     = result_src_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: each scenario pushes the expected W state when it drives
// the M inputs and pops/compares it one cycle later.
module tb_memory_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;

   memory_stage_if m_if ();

   logic        RegWriteW, ResultSrcW, MisalignW;
   logic [4:0]  RD_W;
   logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;

   memory_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .m_if(m_if),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
      .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .MisalignW(MisalignW), .ResultW(ResultW)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [135:0] v;
      logic [135:0] m;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   errors  = 0;

   logic [135:0] obs;
   assign obs = {RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, MisalignW, ResultW, ReadDataW};

   function automatic exp_t mk(string name, logic rw, logic rs, logic [4:0] rd, logic [31:0] alu,
                               logic [31:0] pc4, logic mis, logic [31:0] res,
                               logic [31:0] rdata, logic rdata_valid);
      exp_t x;
      x.name = name;
      x.m = rdata_valid ? {136{1'b1}} : {{104{1'b1}}, 32'h0};
      x.v = {rw, rs, rd, alu, pc4, mis, res, rdata} & x.m;
      return x;
   endfunction

   task automatic drive(logic rw, logic mw, logic rs, logic [4:0] rd, logic [31:0] alu,
                        logic [31:0] wd, logic [31:0] pc4);
      m_if.RegWriteM   = rw;
      m_if.MemWriteM   = mw;
      m_if.ResultSrcM  = rs;
      m_if.RD_M        = rd;
      m_if.ALU_ResultM = alu;
      m_if.WriteDataM  = wd;
      m_if.PCPlus4M    = pc4;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1, 1, 0, 5'd3, 32'h0, 32'hDEADBEEF, 32'h8);
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1));
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if ((obs & e.m) !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
         end
      end
      rst = 1'b1;
      drive(1, 0, 1, 5'd1, 32'h0, 32'h0, 32'h4);
      sb.push_back(mk("reset_load0", 1, 1, 5'd1, 32'h0, 32'h4, 0, 32'h0, 32'h0, 1));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
   endtask

   task automatic test_store_load();
      drive(0, 1, 0, 5'd0, 32'h40, 32'h12345678, 32'h100);
      sb.push_back(mk("store_40", 0, 0, 5'd0, 32'h40, 32'h100, 0, 32'h40, 32'h0, 0));
      @(posedge clk); #1;
      drive(1, 0, 1, 5'd5, 32'h40, 32'h0, 32'h104);
      sb.push_back(mk("load_40", 1, 1, 5'd5, 32'h40, 32'h104, 0, 32'h12345678, 32'h12345678, 1));
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
   endtask

   task automatic test_alu_pass();
      drive(1, 0, 0, 5'd3, 32'h30, 32'hFFFF0000, 32'h104);
      sb.push_back(mk("alu_pass", 1, 0, 5'd3, 32'h30, 32'h104, 0, 32'h30, 32'h0, 0));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
   endtask

   task automatic test_wrap();
      drive(0, 1, 0, 5'd0, 32'h00001004, 32'hA5A5A5A5, 32'h200);
      sb.push_back(mk("wrap_store", 0, 0, 5'd0, 32'h00001004, 32'h200, 0, 32'h00001004, 32'h0, 0));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
      drive(1, 0, 1, 5'd9, 32'h00000004, 32'h0, 32'h204);
      sb.push_back(mk("wrap_load", 1, 1, 5'd9, 32'h4, 32'h204, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
   endtask

   task automatic test_misalign();
      // 0x40 still holds 0x12345678 from the store/load scenario
      drive(0, 1, 0, 5'd0, 32'h42, 32'h11111111, 32'h300);
      sb.push_back(mk("mis_store", 0, 0, 5'd0, 32'h42, 32'h300, 1, 32'h42, 32'h0, 0));
      drive(1, 0, 1, 5'd6, 32'h40, 32'h0, 32'h304);
      sb.push_back(mk("mis_store_kept", 1, 1, 5'd6, 32'h40, 32'h304, 0, 32'h12345678, 32'h12345678, 1));
      drive(1, 0, 1, 5'd7, 32'h43, 32'h0, 32'h308);
      sb.push_back(mk("mis_load", 0, 1, 5'd7, 32'h43, 32'h308, 1, 32'h12345678, 32'h12345678, 1));
      // Illegal load+store encoding: store lands, W captures the pre-store word
      drive(1, 1, 1, 5'd8, 32'h80, 32'hCAFEF00D, 32'h30C);
      sb.push_back(mk("ld_st_illegal", 1, 1, 5'd8, 32'h80, 32'h30C, 0, 32'h0, 32'h0, 1));
      drive(1, 0, 1, 5'd8, 32'h80, 32'h0, 32'h310);
      sb.push_back(mk("ld_st_after", 1, 1, 5'd8, 32'h80, 32'h310, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1));
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   // Stimulus for test_misalign is precomputed; replay it cycle by cycle against the queue.
   task automatic run_misalign();
      logic [31:0] alus[5] = '{32'h42, 32'h40, 32'h43, 32'h80, 32'h80};
      logic [31:0] wds[5]  = '{32'h11111111, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
      logic        mws[5]  = '{1, 0, 0, 1, 0};
      logic        rss[5]  = '{0, 1, 1, 1, 1};
      logic        rws[5]  = '{0, 1, 1, 1, 1};
      logic [4:0]  rds[5]  = '{5'd0, 5'd6, 5'd7, 5'd8, 5'd8};
      test_misalign();
      for (int i = 0; i < 5; i++) begin
         drive(rws[i], mws[i], rss[i], rds[i], alus[i], wds[i], 32'h300 + 32'(4 * i));
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if ((obs & e.m) !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         if (i < 8) begin
            drive(0, 1, 0, 5'd0, 32'(4 * i), 32'(i), 32'h400 + 32'(4 * i));
            sb.push_back(mk($sformatf("b2b_store%0d", i), 0, 0, 5'd0, 32'(4 * i),
                            32'h400 + 32'(4 * i), 0, 32'(4 * i), 32'h0, 0));
         end else begin
            drive(1, 0, 1, 5'(i), 32'(4 * (i - 8)), 32'h0, 32'h400 + 32'(4 * i));
            sb.push_back(mk($sformatf("b2b_load%0d", i - 8), 1, 1, 5'(i), 32'(4 * (i - 8)),
                            32'h400 + 32'(4 * i), 0, 32'(i - 8), 32'(i - 8), 1));
         end
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if ((obs & e.m) !== e.v) begin
            errors++;
            $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive(1, 1, 0, 5'd2, 32'h44, 32'h77777777, 32'h500);
      rst = 1'b0;
      sb.push_back(mk("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
      rst = 1'b1;
      drive(1, 0, 1, 5'd4, 32'h40, 32'h0, 32'h504);
      sb.push_back(mk("mid_reset_cleared", 1, 1, 5'd4, 32'h40, 32'h504, 0, 32'h0, 32'h0, 1));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
      drive(1, 0, 1, 5'd4, 32'h44, 32'h0, 32'h508);
      sb.push_back(mk("mid_reset_st_drop", 1, 1, 5'd4, 32'h44, 32'h508, 0, 32'h0, 32'h0, 1));
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ((obs & e.m) !== e.v) begin
         errors++;
         $display("FAIL %s: got %h want %h", e.name, obs & e.m, e.v);
      end
   endtask

   initial begin
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      test_reset();
      test_store_load();
      test_alu_pass();
      test_wrap();
      run_misalign();
      test_back_to_back();
      test_reset_midstream();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
